// File: rtl/note_voice_scheduler.sv
// note_voice_scheduler: shares one square-wave tone generator between four debounced note keys.
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   note_req    in   [3:0] raw key requests, active-high, asynchronous to clk
//   mode        in   [1:0] 00 off, 01 lowest-index, 10 last-pressed, 11 round-robin
//   held        out  [3:0] debounced key state
//   voice       out  [1:0] index of the granted key
//   tone_en     out  generator enable
//   half_period out  [HP_W-1:0] generator half-period in clk cycles, 0 when silent
//   held_count  out  [2:0] number of held keys
module note_voice_scheduler #(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int SLOT_CYC     = 250000,
   parameter int GAP_CYC      = 64,
   parameter int HP_W         = 17
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [3:0]      note_req,
   input  logic [1:0]      mode,
   output logic [3:0]      held,
   output logic [1:0]      voice,
   output logic            tone_en,
   output logic [HP_W-1:0] half_period,
   output logic [2:0]      held_count
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int SW = $clog2(SLOT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
   state_t          state, state_nx;
   logic [3:0]      s1, s2, flip, rise;
   logic [DW-1:0]   dcnt [4];
   logic [1:0]      last, voice_nx, low, nxt, pick, rr_pick;
   logic [SW-1:0]   slot, slot_nx;
   logic [GW-1:0]   gcnt, gcnt_nx;
   logic            active;

   function automatic logic [1:0] lowest(input logic [3:0] v);
      return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
   endfunction

   // A key flips on the last of DEBOUNCE_CYC consecutive cycles that disagree with held.
   always_comb begin
      for (int k = 0; k < 4; k++) flip[k] = (s2[k] != held[k]) && (dcnt[k] == DW'(DEBOUNCE_CYC - 1));
      rise = flip & s2;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1   <= '0;
         s2   <= '0;
         held <= '0;
         last <= '0;
         for (int k = 0; k < 4; k++) dcnt[k] <= '0;
      end else begin
         s1   <= note_req;
         s2   <= s1;
         held <= held ^ flip;
         if (|rise) last <= lowest(rise);
         for (int k = 0; k < 4; k++) dcnt[k] <= (s2[k] == held[k] || flip[k]) ? '0 : dcnt[k] + 1'b1;
      end
   end

   // nxt: first held key above voice, wrapping; stays on voice when no other key is held.
   always_comb begin
      nxt = voice;
      for (int i = 3; i >= 1; i--) if (held[voice + 2'(i)]) nxt = voice + 2'(i);
      low     = lowest(held);
      rr_pick = (!held[voice] || (state == PLAY && slot == SW'(SLOT_CYC - 1))) ? nxt : voice;
      pick    = mode == 2'b01 ? low : mode == 2'b10 ? (held[last] ? last : low) : rr_pick;
   end

   always_comb begin
      state_nx = state;
      voice_nx = voice;
      slot_nx  = slot;
      gcnt_nx  = gcnt;
      active   = |held && mode != 2'b00;
      if (!active) state_nx = IDLE;
      else if (state == IDLE) begin
         state_nx = PLAY;
         voice_nx = pick;
         slot_nx  = '0;
      end else if (state == PLAY) begin
         slot_nx = slot == SW'(SLOT_CYC - 1) ? '0 : slot + 1'b1;
         if (pick != voice) begin
            state_nx = GAP;
            voice_nx = pick;
            slot_nx  = '0;
            gcnt_nx  = '0;
         end
      end else begin
         // Re-picks during the gap retarget the voice but keep the gap running.
         voice_nx = pick;
         gcnt_nx  = gcnt + 1'b1;
         if (gcnt == GW'(GAP_CYC - 1)) begin
            state_nx = PLAY;
            slot_nx  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         voice <= '0;
         slot  <= '0;
         gcnt  <= '0;
      end else begin
         state <= state_nx;
         voice <= voice_nx;
         slot  <= slot_nx;
         gcnt  <= gcnt_nx;
      end
   end

   assign tone_en     = state == PLAY;
   assign half_period = !tone_en ? '0 : voice == 2'd0 ? HP_W'(95420) : voice == 2'd1 ? HP_W'(75757) :
                        voice == 2'd2 ? HP_W'(63775) : HP_W'(47801);
   assign held_count  = 3'(held[0]) + 3'(held[1]) + 3'(held[2]) + 3'(held[3]);
endmodule
